// File: rtl/feature_vector_packer.sv
// feature_vector_packer
//   Serial-to-parallel front end for the regression output layer. Accepts one
//   signed activation per cycle over valid/ready, optionally clamps negatives
//   to zero (ReLU), packs N samples into one vector and presents it as a held
//   parallel bus with a one-cycle valid pulse. A gap counter keeps consecutive
//   pulses at least GAP+1 cycles apart; a vector completed too early is parked
//   in the fill bank (PEND) with ready_out low until it can be emitted.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low; clears all state
//   valid_in    data_in/last_in valid this cycle
//   data_in     signed activation sample
//   last_in     sample ends the current vector early
//   ready_out   sample accepted this cycle when valid_in is also high
//   vector_out  packed vector, element 0 first, held between pulses
//   valid_out   one-cycle pulse: vector_out is new
//   short_out   qualified by valid_out: vector ended by last_in before N samples
module feature_vector_packer #(
  parameter int N    = 16,
  parameter int DW   = 16,
  parameter bit RELU = 1'b1,
  parameter int GAP  = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         valid_in,
  input  logic signed [DW-1:0]         data_in,
  input  logic                         last_in,
  output logic                         ready_out,
  output logic signed [0:N-1][DW-1:0]  vector_out,
  output logic                         valid_out,
  output logic                         short_out
);

  localparam int IW = $clog2(N);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] PEND = 1'b1;

  logic [0:0]              state;
  logic [IW-1:0]           idx;
  logic [GW-1:0]           gap_cnt;
  logic [0:N-1][DW-1:0]    fill;
  logic                    pend_short;

  logic [DW-1:0]           sample;
  logic                    accept;
  logic                    at_end;
  logic                    complete;
  logic                    gap_zero;
  logic                    emit;
  logic [0:N-1][DW-1:0]    done_vec;
  logic                    done_short;

  assign ready_out = (state == FILL);

  always_comb begin
    // ReLU is a pure sign-bit test; width and value otherwise untouched.
    sample     = (RELU && data_in[DW-1]) ? '0 : data_in;
    accept     = valid_in && (state == FILL);
    at_end     = (idx == IW'(N - 1));
    complete   = accept && (at_end || last_in);
    gap_zero   = (gap_cnt == '0);
    emit       = gap_zero && (complete || (state == PEND));
    // Unwritten entries are already zero: the bank is cleared on every
    // emission and on reset, so early termination needs no extra masking.
    done_vec   = fill;
    done_short = pend_short;
    if (state == FILL) begin
      done_vec[idx] = sample;
      done_short    = !at_end;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= FILL;
      idx        <= '0;
      gap_cnt    <= '0;
      fill       <= '0;
      pend_short <= 1'b0;
      vector_out <= '0;
      valid_out  <= 1'b0;
      short_out  <= 1'b0;
    end else begin
      valid_out <= emit;
      if (emit) begin
        gap_cnt    <= GW'(GAP);
        vector_out <= done_vec;
        short_out  <= done_short;
        fill       <= '0;
        idx        <= '0;
        state      <= FILL;
      end else begin
        if (!gap_zero) begin
          gap_cnt <= gap_cnt - 1'b1;
        end
        if (complete) begin
          // Completed while the gap is still running: park the vector.
          fill       <= done_vec;
          pend_short <= done_short;
          state      <= PEND;
        end else if (accept) begin
          fill[idx] <= sample;
          idx       <= idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_feature_vector_packer.sv
// tb_feature_vector_packer
//   Drives two packer instances from one stimulus stream: A (RELU=1, GAP=3)
//   and B (RELU=0, GAP=0). Each has a reference model built from sample
//   counts and the cycle number of its last pulse. Directed tables and
//   sequences cover ordering, ReLU, early termination, stalls and reset.
module tb_feature_vector_packer;

  logic              clk;
  logic              reset;
  logic              valid_in;
  logic [15:0]       data_in;
  logic              last_in;
  logic              ready_a, valid_a, short_a;
  logic              ready_b, valid_b, short_b;
  logic [0:15][15:0] vec_a, vec_b;

  feature_vector_packer #(.N(16), .DW(16), .RELU(1'b1), .GAP(3)) u_a (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
    .last_in(last_in), .ready_out(ready_a), .vector_out(vec_a),
    .valid_out(valid_a), .short_out(short_a));

  feature_vector_packer #(.N(16), .DW(16), .RELU(1'b0), .GAP(0)) u_b (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
    .last_in(last_in), .ready_out(ready_b), .vector_out(vec_b),
    .valid_out(valid_b), .short_out(short_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  // reference model state, index 0 = A, 1 = B
  logic [15:0] m_buf  [2][16];
  int          m_cnt  [2];
  bit          m_pend [2];
  logic [15:0] m_pvec [2][16];
  bit          m_pshort[2];
  int          m_lastp[2];
  logic [15:0] m_vec  [2][16];
  bit          m_valid[2];
  bit          m_short[2];

  typedef struct {
    logic [15:0] din;
    logic [15:0] exp_relu;
    logic [15:0] exp_raw;
  } vec_t;

  vec_t tbl1[16];
  vec_t tbl2[16];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = 0; m_pend[d] = 0; m_pshort[d] = 0; m_lastp[d] = -1000000;
      m_valid[d] = 0; m_short[d] = 0;
      for (int i = 0; i < 16; i++) begin
        m_buf[d][i] = '0; m_pvec[d][i] = '0; m_vec[d][i] = '0;
      end
    end
  endtask

  // One clock edge of the packer seen as: samples gathered in a list, a
  // vector finishes at 16 samples or on last, and a pulse may only happen
  // more than `gap` cycles after the previous one.
  task automatic model_edge(input int d, input bit relu, input int gap,
                            input bit v, input logic [15:0] din, input bit l);
    logic [15:0] s;
    bit          sh;
    m_valid[d] = 0;
    if (m_pend[d]) begin
      if (cyc - m_lastp[d] > gap) begin
        for (int i = 0; i < 16; i++) m_vec[d][i] = m_pvec[d][i];
        m_short[d] = m_pshort[d]; m_valid[d] = 1; m_lastp[d] = cyc; m_pend[d] = 0;
      end
    end else if (v) begin
      s = (relu && din[15]) ? 16'h0000 : din;
      m_buf[d][m_cnt[d]] = s;
      m_cnt[d]++;
      if (m_cnt[d] == 16 || l) begin
        sh = (m_cnt[d] < 16);
        for (int i = 0; i < 16; i++) m_pvec[d][i] = (i < m_cnt[d]) ? m_buf[d][i] : 16'h0000;
        m_pshort[d] = sh;
        m_cnt[d] = 0;
        if (cyc - m_lastp[d] > gap) begin
          for (int i = 0; i < 16; i++) m_vec[d][i] = m_pvec[d][i];
          m_short[d] = sh; m_valid[d] = 1; m_lastp[d] = cyc;
        end else begin
          m_pend[d] = 1;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [0:15][15:0] ea, eb;
    for (int i = 0; i < 16; i++) begin
      ea[i] = m_vec[0][i];
      eb[i] = m_vec[1][i];
    end
    chk("valid_a", 256'(valid_a), 256'(m_valid[0]));
    chk("ready_a", 256'(ready_a), 256'(!m_pend[0]));
    chk("vector_a", 256'(vec_a), 256'(ea));
    if (m_valid[0]) chk("short_a", 256'(short_a), 256'(m_short[0]));
    chk("valid_b", 256'(valid_b), 256'(m_valid[1]));
    chk("ready_b", 256'(ready_b), 256'(!m_pend[1]));
    chk("vector_b", 256'(vec_b), 256'(eb));
    if (m_valid[1]) chk("short_b", 256'(short_b), 256'(m_short[1]));
  endtask

  task automatic step(input bit v, input logic [15:0] d, input bit l);
    valid_in = v; data_in = d; last_in = l;
    @(posedge clk);
    cyc++;
    model_edge(0, 1'b1, 3, v, d, l);
    model_edge(1, 1'b0, 0, v, d, l);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    chk("rst_valid_a", 256'(valid_a), 256'(0));
    chk("rst_ready_a", 256'(ready_a), 256'(1));
    chk("rst_vector_a", 256'(vec_a), 256'(0));
    chk("rst_short_a", 256'(short_a), 256'(0));
    chk("rst_valid_b", 256'(valid_b), 256'(0));
    chk("rst_ready_b", 256'(ready_b), 256'(1));
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 1'b0);
  endtask

  initial begin
    int k;
    int t1v[16] = '{2875, 0, 5572, 8512, 5511, 3990, 0, 2636,
                    0, 0, 582, 5113, 10592, 9602, 2754, 0};
    int t2v[16] = '{-100, -32768, 7, 1, -1, 32767, 300, -5,
                    12, 0, -2000, 44, 55, -66, 77, 88};
    valid_in = 1'b0; data_in = '0; last_in = 1'b0; reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tbl1[i].din = 16'(t1v[i]); tbl1[i].exp_relu = 16'(t1v[i]); tbl1[i].exp_raw = 16'(t1v[i]);
      tbl2[i].din = 16'(t2v[i]);
      tbl2[i].exp_relu = (t2v[i] < 0) ? 16'h0000 : 16'(t2v[i]);
      tbl2[i].exp_raw = 16'(t2v[i]);
    end

    do_reset();

    // 16 consecutive samples, pulse on the cycle after the last handshake
    for (int i = 0; i < 16; i++) begin
      step(1'b1, tbl1[i].din, 1'b0);
      if (i < 15) chk("t1_no_early_pulse", 256'(valid_a), 256'(0));
    end
    chk("t1_pulse", 256'(valid_a), 256'(1));
    chk("t1_short", 256'(short_a), 256'(0));
    for (int i = 0; i < 16; i++) begin
      chk("t1_elem_a", 256'(vec_a[i]), 256'(tbl1[i].exp_relu));
      chk("t1_elem_b", 256'(vec_b[i]), 256'(tbl1[i].exp_raw));
    end

    // ReLU on A versus pass-through on B
    for (int i = 0; i < 16; i++) step(1'b1, tbl2[i].din, 1'b0);
    chk("t2_pulse", 256'(valid_a), 256'(1));
    for (int i = 0; i < 16; i++) begin
      chk("t2_elem_a", 256'(vec_a[i]), 256'(tbl2[i].exp_relu));
      chk("t2_elem_b", 256'(vec_b[i]), 256'(tbl2[i].exp_raw));
    end

    // early termination after 5 samples, then after 1
    idle(5);
    for (int i = 0; i < 5; i++) step(1'b1, 16'(10 + i), (i == 4));
    chk("t3_pulse", 256'(valid_a), 256'(1));
    chk("t3_short", 256'(short_a), 256'(1));
    chk("t3_elem4", 256'(vec_a[4]), 256'(14));
    chk("t3_elem5", 256'(vec_a[5]), 256'(0));
    idle(5);
    step(1'b1, 16'd99, 1'b1);
    chk("t3_one_pulse", 256'(valid_a), 256'(1));
    chk("t3_one_elem0", 256'(vec_a[0]), 256'(99));
    chk("t3_one_elem1", 256'(vec_a[1]), 256'(0));
    idle(5);
    step(1'b1, 16'd1, 1'b0);
    step(1'b1, 16'd2, 1'b1);
    chk("t3_restart_elem0", 256'(vec_a[0]), 256'(1));

    // stall: second vector completes inside the gap; producer holds its sample
    idle(5);
    step(1'b1, 16'd11, 1'b1);
    chk("stall_first_pulse", 256'(valid_a), 256'(1));
    step(1'b1, 16'd22, 1'b1);
    chk("stall_no_pulse", 256'(valid_a), 256'(0));
    chk("stall_ready_low", 256'(ready_a), 256'(0));
    chk("stall_vec_held", 256'(vec_a[0]), 256'(11));
    k = 0;
    while (k < 10) begin
      step(1'b1, 16'd33, 1'b0);
      k++;
      if (valid_a) break;
    end
    chk("stall_spacing", 256'(k), 256'(3));
    chk("stall_elem0", 256'(vec_a[0]), 256'(22));
    chk("stall_short", 256'(short_a), 256'(1));
    step(1'b1, 16'd33, 1'b1);
    idle(6);

    // last_in without valid_in has no effect
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 16'd5, 1'b1);
      chk("t6_no_pulse", 256'(valid_a), 256'(0));
    end

    // reset mid-fill discards the partial vector
    for (int i = 0; i < 7; i++) step(1'b1, 16'(500 + i), 1'b0);
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 16'(100 + i), 1'b0);
    chk("t5_pulse", 256'(valid_a), 256'(1));
    chk("t5_elem0", 256'(vec_a[0]), 256'(100));
    chk("t5_elem15", 256'(vec_a[15]), 256'(115));

    // randomized traffic against the models
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 9) < 7), 16'($urandom), ($urandom_range(0, 9) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
